// File: rtl/video_pattern_gen.sv
// video_pattern_gen: self-timed raster generator with test patterns.
// Stage 1 registers region flags and pattern selects from the raster counters.
// Stage 2 registers colour and syncs. Shadow registers are loaded at frame start,
// so every pattern parameter changes only on a frame boundary.
module video_pattern_gen #(
    parameter int   H_ACTIVE = 1280,
    parameter int   H_FP     = 110,
    parameter int   H_SYNC   = 40,
    parameter int   H_BP     = 220,
    parameter int   V_ACTIVE = 720,
    parameter int   V_FP     = 5,
    parameter int   V_SYNC   = 5,
    parameter int   V_BP     = 20,
    parameter logic HS_POL   = 1'b1,
    parameter logic VS_POL   = 1'b1,
    parameter int   CW       = 8,
    parameter int   CNT_W    = 12,
    parameter int   BOX      = 64
) (
    input  logic          I_pix_clk,
    input  logic          I_rst_n,
    input  logic          I_cfg_we,
    input  logic [2:0]    I_cfg_adr,
    input  logic [7:0]    I_cfg_dat,
    output logic [7:0]    O_cfg_dat,
    output logic [CW-1:0] O_rgb_r,
    output logic [CW-1:0] O_rgb_g,
    output logic [CW-1:0] O_rgb_b,
    output logic          O_de,
    output logic          O_hs,
    output logic          O_vs,
    output logic [15:0]   O_frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BW      = CNT_W + 9;

    localparam logic [CNT_W-1:0] C_H_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_V_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] C_H_ACT   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] C_V_ACT   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] C_HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] C_HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] C_VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] C_VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] C_BOX_Y0  = CNT_W'(V_ACTIVE / 2 - BOX / 2);
    localparam logic [CNT_W-1:0] C_BOX_Y1  = CNT_W'(V_ACTIVE / 2 - BOX / 2 + BOX);
    localparam logic [BW-1:0]    C_BOX_MAX = BW'(H_ACTIVE - BOX);
    localparam logic [CNT_W:0]   C_BOX     = (CNT_W + 1)'(BOX);

    // 8-bit register value to CW bits, MSB aligned (pad or truncate at the bottom)
    function automatic logic [CW-1:0] f_map(input logic [7:0] v);
        logic [CW+7:0] t;
        t = {v, {CW{1'b0}}};
        return t[CW+7 -: CW];
    endfunction

    logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
    logic             w_h_last, w_v_last, w_fs;

    assign w_h_last = (r_h_cnt == C_H_LAST);
    assign w_v_last = (r_v_cnt == C_V_LAST);
    assign w_fs     = (r_h_cnt == '0) && (r_v_cnt == '0);

    // raster counters: h wraps every line, v advances on h wrap
    always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
        end else begin
            r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
    end

    logic [2:0] r_mode, r_chk;
    logic [7:0] r_sol_r, r_sol_g, r_sol_b, r_step;
    logic       r_en;

    // live configuration registers; address 7 is reserved and ignored
    always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_mode  <= '0;
            r_sol_r <= '0;
            r_sol_g <= '0;
            r_sol_b <= '0;
            r_chk   <= '0;
            r_step  <= '0;
            r_en    <= 1'b0;
        end else if (I_cfg_we) begin
            case (I_cfg_adr)
                3'd0:    r_mode  <= I_cfg_dat[2:0];
                3'd1:    r_sol_r <= I_cfg_dat;
                3'd2:    r_sol_g <= I_cfg_dat;
                3'd3:    r_sol_b <= I_cfg_dat;
                3'd4:    r_chk   <= I_cfg_dat[2:0];
                3'd5:    r_step  <= I_cfg_dat;
                3'd6:    r_en    <= I_cfg_dat[0];
                default: ;
            endcase
        end
    end

    // readback of live registers; unused bits and address 7 read zero
    always_comb begin
        O_cfg_dat = '0;
        case (I_cfg_adr)
            3'd0:    O_cfg_dat = {5'b0, r_mode};
            3'd1:    O_cfg_dat = r_sol_r;
            3'd2:    O_cfg_dat = r_sol_g;
            3'd3:    O_cfg_dat = r_sol_b;
            3'd4:    O_cfg_dat = {5'b0, r_chk};
            3'd5:    O_cfg_dat = r_step;
            3'd6:    O_cfg_dat = {7'b0, r_en};
            default: ;
        endcase
    end

    logic [2:0] r_s_mode, r_s_chk;
    logic [7:0] r_s_r, r_s_g, r_s_b;
    logic       r_s_en;
    logic [15:0] r_frame_cnt;

    // frame start: snapshot live registers (pre-write value) and count the frame
    always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_s_mode    <= '0;
            r_s_chk     <= '0;
            r_s_r       <= '0;
            r_s_g       <= '0;
            r_s_b       <= '0;
            r_s_en      <= 1'b0;
            r_frame_cnt <= '0;
        end else if (w_fs) begin
            r_s_mode    <= r_mode;
            r_s_chk     <= r_chk;
            r_s_r       <= r_sol_r;
            r_s_g       <= r_sol_g;
            r_s_b       <= r_sol_b;
            r_s_en      <= r_en;
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    logic [CNT_W-1:0] r_box_x;
    logic             r_dir_left;
    logic [BW-1:0]    w_bx, w_step, w_sum, w_diff;

    // the step used at frame start is the value the shadow captures in that cycle
    assign w_bx   = BW'(r_box_x);
    assign w_step = BW'(r_step);
    assign w_sum  = w_bx + w_step;
    assign w_diff = w_bx - w_step;

    // box bounces between 0 and H_ACTIVE-BOX, one step per frame, in every mode
    always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r_box_x    <= '0;
            r_dir_left <= 1'b0;
        end else if (w_fs) begin
            if (!r_dir_left) begin
                if (w_sum > C_BOX_MAX) begin
                    r_box_x    <= C_BOX_MAX[CNT_W-1:0];
                    r_dir_left <= 1'b1;
                end else begin
                    r_box_x <= w_sum[CNT_W-1:0];
                end
            end else if (w_step > w_bx) begin
                r_box_x    <= '0;
                r_dir_left <= 1'b0;
            end else begin
                r_box_x <= w_diff[CNT_W-1:0];
            end
        end
    end

    logic [2:0] w_bar;

    // bar index by comparison ladder; remainder pixels fall into the last bar
    always_comb begin
        w_bar = '0;
        for (int k = 1; k < 8; k++)
            if (r_h_cnt >= CNT_W'(k * BAR_W)) w_bar = 3'(k);
    end

    logic             r1_act, r1_hs, r1_vs, r1_box_row;
    logic [2:0]       r1_bar;
    logic [CNT_W-1:0] r1_x, r1_y;

    // stage 1: region flags, sync windows and shadow-independent selects
    always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r1_act     <= 1'b0;
            r1_hs      <= 1'b0;
            r1_vs      <= 1'b0;
            r1_box_row <= 1'b0;
            r1_bar     <= '0;
            r1_x       <= '0;
            r1_y       <= '0;
        end else begin
            r1_act     <= (r_h_cnt < C_H_ACT) && (r_v_cnt < C_V_ACT);
            r1_hs      <= (r_h_cnt >= C_HS_BEG) && (r_h_cnt < C_HS_END);
            r1_vs      <= (r_v_cnt >= C_VS_BEG) && (r_v_cnt < C_VS_END);
            r1_box_row <= (r_v_cnt >= C_BOX_Y0) && (r_v_cnt < C_BOX_Y1);
            r1_bar     <= w_bar;
            r1_x       <= r_h_cnt;
            r1_y       <= r_v_cnt;
        end
    end

    logic [CNT_W-1:0]    w_cx, w_cy;
    logic [CNT_W+CW-1:0] w_gx;
    logic                w_chk_on, w_in_box;
    logic [CW-1:0]       w_sr, w_sg, w_sb, w_r, w_g, w_b;

    assign w_cx     = r1_x >> r_s_chk;
    assign w_cy     = r1_y >> r_s_chk;
    assign w_chk_on = w_cx[0] ^ w_cy[0];
    assign w_gx     = (CNT_W + CW)'(r1_x);
    assign w_in_box = r1_box_row && (r1_x >= r_box_x) &&
                      ({1'b0, r1_x} < ({1'b0, r_box_x} + C_BOX));
    assign w_sr     = f_map(r_s_r);
    assign w_sg     = f_map(r_s_g);
    assign w_sb     = f_map(r_s_b);

    // colour select from shadow mode, then blanking and enable gating
    always_comb begin
        w_r = '0;
        w_g = '0;
        w_b = '0;
        case (r_s_mode)
            3'd0: begin
                w_r = w_sr; w_g = w_sg; w_b = w_sb;
            end
            3'd1: begin
                w_r = {CW{~r1_bar[1]}};
                w_g = {CW{~r1_bar[2]}};
                w_b = {CW{~r1_bar[0]}};
            end
            3'd2: begin
                w_r = {CW{w_chk_on}}; w_g = {CW{w_chk_on}}; w_b = {CW{w_chk_on}};
            end
            3'd3: begin
                w_r = w_gx[CW-1:0]; w_g = w_gx[CW-1:0]; w_b = w_gx[CW-1:0];
            end
            3'd4: begin
                if (w_in_box) begin
                    w_r = '1; w_g = '1; w_b = '1;
                end else begin
                    w_r = w_sr; w_g = w_sg; w_b = w_sb;
                end
            end
            default: ;
        endcase
        if (!r1_act || !r_s_en) begin
            w_r = '0; w_g = '0; w_b = '0;
        end
    end

    logic [CW-1:0] r2_r, r2_g, r2_b;
    logic          r2_de, r2_hs, r2_vs;

    // stage 2: registered colour and syncs, mutually aligned
    always_ff @(posedge I_pix_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            r2_r  <= '0;
            r2_g  <= '0;
            r2_b  <= '0;
            r2_de <= 1'b0;
            r2_hs <= ~HS_POL;
            r2_vs <= ~VS_POL;
        end else begin
            r2_r  <= w_r;
            r2_g  <= w_g;
            r2_b  <= w_b;
            r2_de <= r1_act;
            r2_hs <= r1_hs ? HS_POL : ~HS_POL;
            r2_vs <= r1_vs ? VS_POL : ~VS_POL;
        end
    end

    assign O_rgb_r     = r2_r;
    assign O_rgb_g     = r2_g;
    assign O_rgb_b     = r2_b;
    assign O_de        = r2_de;
    assign O_hs        = r2_hs;
    assign O_vs        = r2_vs;
    assign O_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a 22x11 raster (16x8 active, BOX=4).
// Output after edge n reflects raster index n-2; pixel (x,y) of frame f appears
// after edge f*242 + y*22 + x + 2, counting edges from reset release.
module tb_video_pattern_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  adr = '0;
    logic [7:0]  wdat = '0;
    logic [7:0]  rdat;
    logic [7:0]  o_r, o_g, o_b;
    logic        o_de, o_hs, o_vs;
    logic [15:0] o_fc;

    int total = 0;
    int bad = 0;
    int edge_n = 0;

    video_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(8), .CNT_W(12), .BOX(4)
    ) dut (
        .I_pix_clk(clk), .I_rst_n(rst_n),
        .I_cfg_we(we), .I_cfg_adr(adr), .I_cfg_dat(wdat), .O_cfg_dat(rdat),
        .O_rgb_r(o_r), .O_rgb_g(o_g), .O_rgb_b(o_b),
        .O_de(o_de), .O_hs(o_hs), .O_vs(o_vs), .O_frame_cnt(o_fc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
    endtask

    task automatic run_to(input int e);
        while (edge_n < e) tick();
    endtask

    task automatic do_reset();
        we = 1'b0;
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        edge_n = 0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        adr = a; wdat = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic get_pix(input int f, input int x, input int y, output logic [23:0] v);
        run_to(f * 242 + y * 22 + x + 2);
        v = {o_r, o_g, o_b};
    endtask

    function automatic logic [23:0] bar_col(input int i);
        case (i)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic test_reset();
        #3;
        total++; if ({o_r, o_g, o_b} !== 24'h0) begin bad++; $display("FAIL rst_rgb got %h want 000000", {o_r, o_g, o_b}); end
        total++; if ({o_de, o_hs, o_vs} !== 3'b000) begin bad++; $display("FAIL rst_syncs got %b want 000", {o_de, o_hs, o_vs}); end
        total++; if (o_fc !== 16'd0) begin bad++; $display("FAIL rst_fcnt got %0d want 0", o_fc); end
        for (int a = 0; a < 8; a++) begin
            adr = 3'(a); #1;
            total++; if (rdat !== 8'h00) begin bad++; $display("FAIL rst_reg%0d got %h want 00", a, rdat); end
        end
        @(negedge clk);
        rst_n = 1'b1;
        edge_n = 0;
        tick();
        total++; if (o_fc !== 16'd1) begin bad++; $display("FAIL first_fs_fcnt got %0d want 1", o_fc); end
        total++; if (o_de !== 1'b0) begin bad++; $display("FAIL de_edge1 got %b want 0", o_de); end
        tick();
        total++; if (o_de !== 1'b1) begin bad++; $display("FAIL de_edge2 got %b want 1", o_de); end
    endtask

    task automatic test_regs();
        logic [7:0] exp [8];
        do_reset();
        wr(3'd0, 8'hFF); wr(3'd1, 8'hA5); wr(3'd4, 8'hFF);
        wr(3'd5, 8'hFF); wr(3'd6, 8'hFF); wr(3'd7, 8'hFF);
        exp = '{8'h07, 8'hA5, 8'h00, 8'h00, 8'h07, 8'hFF, 8'h01, 8'h00};
        for (int a = 0; a < 8; a++) begin
            adr = 3'(a); #1;
            total++; if (rdat !== exp[a]) begin bad++; $display("FAIL readback%0d got %h want %h", a, rdat, exp[a]); end
        end
    endtask

    task automatic test_timing();
        int idx, h, v;
        int de_err = 0, hs_err = 0, vs_err = 0, vs_hi = 0, de_l0 = 0;
        int de_r1 = -1, de_r2 = -1, hs_r1 = -1;
        logic [15:0] fc242 = '0, fc243 = '0;
        logic ede, ehs, evs, pde = 1'b0, phs = 1'b0;
        do_reset();
        for (int n = 1; n <= 484; n++) begin
            tick();
            idx = n - 2;
            if (idx < 0) begin
                ede = 1'b0; ehs = 1'b0; evs = 1'b0;
            end else begin
                h = idx % 22; v = (idx / 22) % 11;
                ede = (h < 16) && (v < 8);
                ehs = (h >= 18) && (h < 20);
                evs = (v == 9);
            end
            if (o_de !== ede) de_err++;
            if (o_hs !== ehs) hs_err++;
            if (o_vs !== evs) vs_err++;
            if (o_vs && n <= 243) vs_hi++;
            if (o_de && n >= 2 && n <= 23) de_l0++;
            if (o_de && !pde) begin
                if (de_r1 < 0) de_r1 = n;
                else if (n > 200 && de_r2 < 0) de_r2 = n;
            end
            if (o_hs && !phs && hs_r1 < 0) hs_r1 = n;
            if (n == 242) fc242 = o_fc;
            if (n == 243) fc243 = o_fc;
            pde = o_de; phs = o_hs;
        end
        total++; if (de_err != 0) begin bad++; $display("FAIL de_pattern got %0d wrong cycles want 0", de_err); end
        total++; if (hs_err != 0) begin bad++; $display("FAIL hs_pattern got %0d wrong cycles want 0", hs_err); end
        total++; if (vs_err != 0) begin bad++; $display("FAIL vs_pattern got %0d wrong cycles want 0", vs_err); end
        total++; if (de_l0 != 16) begin bad++; $display("FAIL de_width got %0d want 16", de_l0); end
        total++; if (hs_r1 - de_r1 != 18) begin bad++; $display("FAIL hs_offset got %0d want 18", hs_r1 - de_r1); end
        total++; if (vs_hi != 22) begin bad++; $display("FAIL vs_width got %0d want 22", vs_hi); end
        total++; if (de_r2 - de_r1 != 242) begin bad++; $display("FAIL frame_period got %0d want 242", de_r2 - de_r1); end
        total++; if (fc242 !== 16'd1) begin bad++; $display("FAIL fcnt_e242 got %0d want 1", fc242); end
        total++; if (fc243 !== 16'd2) begin bad++; $display("FAIL fcnt_e243 got %0d want 2", fc243); end
        total++; if (o_fc !== 16'd2) begin bad++; $display("FAIL fcnt_2frames got %0d want 2", o_fc); end
    endtask

    task automatic test_bars();
        logic [23:0] p;
        int ys [3];
        ys = '{0, 3, 7};
        do_reset();
        wr(3'd0, 8'd1);
        wr(3'd6, 8'd1);
        get_pix(0, 0, 1, p);
        total++; if (p !== 24'h0) begin bad++; $display("FAIL bars_frame0 got %h want 000000", p); end
        for (int j = 0; j < 3; j++)
            for (int x = 0; x < 16; x++) begin
                get_pix(1, x, ys[j], p);
                total++; if (p !== bar_col(x / 2)) begin bad++; $display("FAIL bars x=%0d y=%0d got %h want %h", x, ys[j], p, bar_col(x / 2)); end
            end
    endtask

    task automatic test_shadow();
        logic [23:0] p;
        do_reset();
        run_to(50);
        wr(3'd1, 8'h12); wr(3'd2, 8'h34); wr(3'd3, 8'h56); wr(3'd0, 8'd0); wr(3'd6, 8'd1);
        get_pix(0, 0, 3, p);
        total++; if (p !== 24'h0) begin bad++; $display("FAIL shadow_cur_a got %h want 000000", p); end
        get_pix(0, 15, 7, p);
        total++; if (p !== 24'h0) begin bad++; $display("FAIL shadow_cur_b got %h want 000000", p); end
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 16; x++) begin
                get_pix(1, x, y, p);
                total++; if (p !== 24'h123456) begin bad++; $display("FAIL shadow_next x=%0d y=%0d got %h want 123456", x, y, p); end
            end
        run_to(484);
        wr(3'd1, 8'hAB);
        adr = 3'd1; #1;
        total++; if (rdat !== 8'hAB) begin bad++; $display("FAIL fs_write_live got %h want ab", rdat); end
        get_pix(2, 0, 0, p);
        total++; if (p !== 24'h123456) begin bad++; $display("FAIL fs_write_f2_first got %h want 123456", p); end
        get_pix(2, 3, 3, p);
        total++; if (p !== 24'h123456) begin bad++; $display("FAIL fs_write_f2 got %h want 123456", p); end
        get_pix(3, 3, 3, p);
        total++; if (p !== 24'hAB3456) begin bad++; $display("FAIL fs_write_f3 got %h want ab3456", p); end
    endtask

    task automatic test_checker();
        logic [23:0] p;
        int xs [5], ys [5];
        logic [23:0] ex [5];
        xs = '{0, 2, 3, 2, 4};
        ys = '{0, 0, 1, 2, 2};
        ex = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'hFFFFFF};
        do_reset();
        wr(3'd0, 8'd2); wr(3'd4, 8'd1); wr(3'd6, 8'd1);
        for (int i = 0; i < 5; i++) begin
            get_pix(1, xs[i], ys[i], p);
            total++; if (p !== ex[i]) begin bad++; $display("FAIL checker (%0d,%0d) got %h want %h", xs[i], ys[i], p, ex[i]); end
        end
    endtask

    task automatic test_gradient();
        logic [23:0] p;
        do_reset();
        wr(3'd0, 8'd3); wr(3'd6, 8'd1);
        get_pix(1, 5, 2, p);
        total++; if (p !== 24'h050505) begin bad++; $display("FAIL grad_5 got %h want 050505", p); end
        get_pix(1, 17, 2, p);
        total++; if (p !== 24'h000000) begin bad++; $display("FAIL grad_blank got %h want 000000", p); end
        get_pix(1, 15, 7, p);
        total++; if (p !== 24'h0F0F0F) begin bad++; $display("FAIL grad_15 got %h want 0f0f0f", p); end
        run_to(419);
        wr(3'd6, 8'd0);
        get_pix(2, 5, 2, p);
        total++; if (p !== 24'h000000) begin bad++; $display("FAIL disabled got %h want 000000", p); end
        run_to(599);
        wr(3'd6, 8'd1); wr(3'd0, 8'd5);
        get_pix(3, 5, 2, p);
        total++; if (p !== 24'h000000) begin bad++; $display("FAIL mode5 got %h want 000000", p); end
    endtask

    task automatic test_box();
        logic [23:0] p;
        int bxs [7];
        int bx;
        bxs = '{5, 10, 12, 7, 2, 0, 5};
        do_reset();
        wr(3'd0, 8'd4); wr(3'd5, 8'd5); wr(3'd3, 8'h40); wr(3'd6, 8'd1);
        for (int f = 1; f <= 7; f++) begin
            bx = bxs[f - 1];
            if (bx > 0) begin
                get_pix(f, bx - 1, 3, p);
                total++; if (p !== 24'h000040) begin bad++; $display("FAIL box f%0d left got %h want 000040", f, p); end
            end
            get_pix(f, bx, 3, p);
            total++; if (p !== 24'hFFFFFF) begin bad++; $display("FAIL box f%0d x0 got %h want ffffff", f, p); end
            get_pix(f, bx + 3, 3, p);
            total++; if (p !== 24'hFFFFFF) begin bad++; $display("FAIL box f%0d x3 got %h want ffffff", f, p); end
            if (bx + 4 < 16) begin
                get_pix(f, bx + 4, 3, p);
                total++; if (p !== 24'h000040) begin bad++; $display("FAIL box f%0d right got %h want 000040", f, p); end
            end
        end
        get_pix(8, 10, 1, p);
        total++; if (p !== 24'h000040) begin bad++; $display("FAIL box_row1 got %h want 000040", p); end
        get_pix(8, 10, 2, p);
        total++; if (p !== 24'hFFFFFF) begin bad++; $display("FAIL box_row2 got %h want ffffff", p); end
        get_pix(8, 10, 5, p);
        total++; if (p !== 24'hFFFFFF) begin bad++; $display("FAIL box_row5 got %h want ffffff", p); end
        get_pix(8, 10, 6, p);
        total++; if (p !== 24'h000040) begin bad++; $display("FAIL box_row6 got %h want 000040", p); end
    endtask

    task automatic test_midreset();
        logic [23:0] p;
        get_pix(9, 12, 3, p);
        #2 rst_n = 1'b0;
        #1;
        adr = 3'd0; #0;
        total++; if ({o_r, o_g, o_b} !== 24'h0) begin bad++; $display("FAIL midrst_rgb got %h want 000000", {o_r, o_g, o_b}); end
        total++; if ({o_de, o_hs, o_vs} !== 3'b000) begin bad++; $display("FAIL midrst_syncs got %b want 000", {o_de, o_hs, o_vs}); end
        total++; if (o_fc !== 16'd0) begin bad++; $display("FAIL midrst_fcnt got %0d want 0", o_fc); end
        #1;
        total++; if (rdat !== 8'h00) begin bad++; $display("FAIL midrst_mode got %h want 00", rdat); end
        @(negedge clk);
        rst_n = 1'b1;
        edge_n = 0;
        tick();
        total++; if (o_fc !== 16'd1) begin bad++; $display("FAIL midrst_fs got %0d want 1", o_fc); end
        total++; if (o_de !== 1'b0) begin bad++; $display("FAIL midrst_de got %b want 0", o_de); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_timing();
        test_bars();
        test_shadow();
        test_checker();
        test_gradient();
        test_box();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

Single-clock, parametrised video timing and test-pattern generator for the HDMI output path. It generates its own raster timing from parameters, so it needs no PHY counters. It drives RGB/DE/HS/VS straight into the PHY RGB inputs. It extends the fixed-mode pattern source with configurable colour depth, timing, frame-synchronous register updates, a frame counter and an animated bouncing-box mode.

## Interface
- H_ACTIVE, 1280, active pixels per line
- H_FP / H_SYNC / H_BP, 110 / 40 / 220, horizontal porches and sync width in pixels
- V_ACTIVE, 720, active lines
- V_FP / V_SYNC / V_BP, 5 / 5 / 20, vertical porches and sync width in lines
- HS_POL / VS_POL, 1 / 1, active level of HS/VS
- CW, 8, bits per colour channel
- CNT_W, 12, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- BOX, 64, box edge length in pixels for mode 4

Ports:
- I_pix_clk  in  1  pixel clock; the only clock
- I_rst_n  in  1  reset, asynchronous, active-low
- I_cfg_we  in  1  register write strobe, one write per cycle
- I_cfg_adr  in  3  register address
- I_cfg_dat  in  8  write data
- O_cfg_dat  out  8  combinational readback of the live register at I_cfg_adr
- O_rgb_r / O_rgb_g / O_rgb_b  out  CW  pixel colour
- O_de / O_hs / O_vs  out  1  data enable and syncs
- O_frame_cnt  out  16  frames started since reset, wraps

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Raster counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps.
  - v_cnt increments when h_cnt wraps, and wraps at V_TOTAL-1.
  - Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - HS is active for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - VS is active for the same window on v_cnt, for whole lines.
- Registers, all reset to 0:
  - 0 MODE[2:0]
  - 1 SOLID_R
  - 2 SOLID_G
  - 3 SOLID_B
  - 4 CHK_SHIFT[2:0]
  - 5 BOX_STEP[7:0]
  - 6 ENABLE[0]
  - 7 reserved; writes are ignored and it reads 0.
  - Unused register bits read 0.
  - SOLID_* values map to CW bits by MSB alignment: zero-padded when CW>8, truncated to the top CW bits when CW<8.
- Frame start (FS) is the cycle where h_cnt==0 and v_cnt==0. At FS:
  - All live registers are copied to shadow registers.
  - The box position updates.
  - O_frame_cnt increments.
  - Patterns use shadow values only.
  - A write in the FS cycle updates the live register, but the shadow takes the pre-write value, so the write takes effect at the next FS.
- Modes, where x = h_cnt and y = v_cnt in the active region, and W = all-ones:
  - 0 solid: SOLID colour.
  - 1 colour bars: eight bars of width H_ACTIVE/8 (integer division); remainder pixels belong to the last bar. Order is white, yellow, cyan, green, magenta, red, blue, black.
  - 2 checker: white if ((x>>CHK_SHIFT) ^ (y>>CHK_SHIFT)) bit 0 is 1, else black.
  - 3 gradient: r = g = b = x[CW-1:0], wrapping every 2^CW pixels.
  - 4 box: white BOX×BOX square at (box_x, V_ACTIVE/2-BOX/2) over the SOLID background.
  - 5-7: black.
- Box motion, updated at FS:
  - Direction dir resets to right; box_x resets to 0.
  - Moving right: if box_x+STEP > H_ACTIVE-BOX, set box_x = H_ACTIVE-BOX and dir = left; otherwise box_x += STEP.
  - Moving left: if STEP > box_x, set box_x = 0 and dir = right; otherwise box_x -= STEP.
  - STEP=0 freezes the box.
  - The update applies even when not in mode 4.
- Output gating:
  - When shadow ENABLE=0, RGB is 0 but DE, HS and VS still run.
  - Outside the active region, RGB is 0.

## Timing
- Two-stage pipeline: stage 1 registers region flags and pattern selects; stage 2 registers colour and syncs.
- O_* outputs reflect the counter state from 2 cycles earlier. RGB, DE, HS and VS are mutually aligned.
- Reset values:
  - h_cnt = v_cnt = 0.
  - RGB = 0, O_de = 0.
  - O_hs = ~HS_POL, O_vs = ~VS_POL.
  - O_frame_cnt = 0, box_x = 0, all registers and shadows 0.
- After reset release, the first clock edge is an FS, so O_frame_cnt becomes 1. O_de first goes high on the 2nd edge.
- Reset asserted mid-frame clears everything immediately, asynchronously. No partial line is emitted.
- O_frame_cnt increments at the FS edge and wraps from 0xFFFF to 0.

## Test plan
All scenarios use small parameters: H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=22); V_ACTIVE=8, V_FP=V_SYNC=V_BP=1 (V_TOTAL=11); BOX=4; CW=8.
- Timing: run 2 frames -> per line, DE is high for 16 cycles and HS is high for 2 cycles, starting 18 cycles after DE rises. VS is high for 22 cycles per frame. The frame period is 242 cycles and O_frame_cnt=2.
- Bars: MODE=1, ENABLE=1 -> each line outputs 2 pixels of FFFFFF, then FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- Shadow: MODE=0, SOLID=12/34/56, ENABLE=1 written mid-frame -> the current frame stays black; the next frame is 123456 on all 128 active pixels. A write in the FS cycle takes effect one frame later.
- Checker: MODE=2, CHK_SHIFT=1 -> pixel (0,0) is 000000, (2,0) is FFFFFF, (2,2) is 000000.
- Box: MODE=4, BOX_STEP=5 -> box_x runs 5, 10, 12 (reverses to left), 7, 2, 0 (reverses to right). Box pixels are white at rows 2-5.
- Reset: assert I_rst_n low mid-line -> all outputs return to their reset values without waiting for a clock. After release, O_frame_cnt=1 following the first edge.
